// File: rtl/rule110_host_pkg.sv
// Shared encodings for the rule-110 host controller: command ops, FSM states
// and the bit layout of the target's control pins.
package rule110_host_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_RUN  = 2'b01,
      OP_DUMP = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_WAIT,
      S_LD_WR,
      S_RUN,
      S_DP_ADDR,
      S_DP_SYNC1,
      S_DP_SYNC2,
      S_DP_CAP,
      S_DP_OUT,
      S_FIN
   } state_e;

   localparam int unsigned CTRL_WE_N     = 0;
   localparam int unsigned CTRL_HALT_N   = 1;
   localparam int unsigned CTRL_ADDR_LSB = 2;

   localparam logic [7:0] PIN_CTRL_RST = 8'h01;

endpackage

// File: rtl/rule110_pin_sync.sv
// Two-flop synchronizer for the target's data-out pins; only instantiated
// when PIN_SYNC_EN is defined (target on another clock or off-chip).
module rule110_pin_sync #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rule110_host_ctrl.sv
// Host-side initiator for the rule-110 automaton pins: LOAD / RUN / DUMP.
// Define PIN_SYNC_EN to synchronize pin_q and add two wait states per DUMP byte.
module rule110_host_ctrl
   import rule110_host_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 16,
   parameter int unsigned ADDR_BITS  = 6,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [7:0]       wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [7:0]       rd_data,
   output logic             rd_last,
   output logic             busy,
   output logic             done,
   output logic [7:0]       pin_data,
   output logic [7:0]       pin_ctrl,
   input  logic [7:0]       pin_q
);

   localparam logic [ADDR_BITS-1:0] LAST_BLK = ADDR_BITS'(NUM_BLOCKS - 1);
   localparam logic [ADDR_BITS-1:0] BLK_ONE  = ADDR_BITS'(1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] blk_q, blk_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           pin_data_q, pin_data_d;
   logic                 we_n_q, we_n_d;
   logic                 halt_n_q, halt_n_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic [7:0]           cap_src;

   logic cmd_fire;
   logic wr_fire;
   logic rd_fire;

`ifdef PIN_SYNC_EN
   rule110_pin_sync #(
      .WIDTH (8)
   ) u_pin_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (pin_q),
      .q_o   (cap_src)
   );
`else
   assign cap_src = pin_q;
`endif

   assign cmd_fire = cmd_valid && (state_q == S_IDLE);
   assign wr_fire  = wr_valid && (state_q == S_LD_WAIT);
   assign rd_fire  = rd_ready && (state_q == S_DP_OUT);

   // State register: FSM state plus every registered pin and data output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         blk_q      <= '0;
         cnt_q      <= '0;
         pin_data_q <= '0;
         we_n_q     <= 1'b1;
         halt_n_q   <= 1'b0;
         addr_q     <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         cnt_q      <= cnt_d;
         pin_data_q <= pin_data_d;
         we_n_q     <= we_n_d;
         halt_n_q   <= halt_n_d;
         addr_q     <= addr_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               blk_d = '0;
               unique case (op_e'(cmd_op))
                  OP_LOAD: state_d = S_LD_WAIT;
                  OP_RUN: begin
                     cnt_d   = cmd_arg;
                     state_d = (cmd_arg == '0) ? S_FIN : S_RUN;
                  end
                  OP_DUMP: state_d = S_DP_ADDR;
                  default: state_d = S_FIN;
               endcase
            end
         end
         S_LD_WAIT: begin
            if (wr_fire) begin
               state_d = S_LD_WR;
            end
         end
         S_LD_WR: begin
            blk_d   = blk_q + BLK_ONE;
            state_d = (blk_q == LAST_BLK) ? S_FIN : S_LD_WAIT;
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_FIN;
            end
         end
         S_DP_ADDR: begin
`ifdef PIN_SYNC_EN
            state_d = S_DP_SYNC1;
`else
            state_d = S_DP_CAP;
`endif
         end
         S_DP_SYNC1: state_d = S_DP_SYNC2;
         S_DP_SYNC2: state_d = S_DP_CAP;
         S_DP_CAP:   state_d = S_DP_OUT;
         S_DP_OUT: begin
            if (rd_fire) begin
               if (blk_q == LAST_BLK) begin
                  state_d = S_FIN;
               end else begin
                  blk_d   = blk_q + BLK_ONE;
                  state_d = S_DP_ADDR;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are decoded from the upcoming state so the registered pins
   // line up with state_q: we_n low exactly in LD_WR, halt_n high exactly in RUN.
   always_comb begin
      pin_data_d = pin_data_q;
      we_n_d     = 1'b1;
      halt_n_d   = 1'b0;
      addr_d     = addr_q;
      rd_data_d  = rd_data_q;
      unique case (state_d)
         S_IDLE: addr_d = '0;
         S_LD_WR: begin
            we_n_d = 1'b0;
            addr_d = blk_d;
         end
         S_RUN:      halt_n_d = 1'b1;
         S_DP_ADDR,
         S_DP_SYNC1,
         S_DP_SYNC2,
         S_DP_CAP,
         S_DP_OUT:   addr_d = blk_d;
         default: ;
      endcase
      if (wr_fire) begin
         pin_data_d = wr_data;
      end
      if (state_q == S_DP_CAP) begin
         rd_data_d = cap_src;
      end
   end

   always_comb begin
      pin_ctrl                                 = '0;
      pin_ctrl[CTRL_WE_N]                      = we_n_q;
      pin_ctrl[CTRL_HALT_N]                    = halt_n_q;
      pin_ctrl[CTRL_ADDR_LSB +: ADDR_BITS]     = addr_q;
   end

   assign pin_data  = pin_data_q;
   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign wr_ready  = (state_q == S_LD_WAIT);
   assign rd_valid  = (state_q == S_DP_OUT);
   assign rd_last   = (state_q == S_DP_OUT) && (blk_q == LAST_BLK);
   assign rd_data   = rd_data_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_rule110_host_ctrl.sv
// Directed bench for rule110_host_ctrl with a behavioural 128-cell rule-110 target.
module tb_rule110_host_ctrl;
   import rule110_host_pkg::*;

   typedef logic [127:0] v_t;
   localparam logic [7:0] RULE110 = 8'd110;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b11;
   logic [15:0] cmd_arg = '0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [7:0]  wr_data = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_last;
   logic        busy;
   logic        done;
   logic [7:0]  pin_data;
   logic [7:0]  pin_ctrl;
   logic [7:0]  pin_q;

   int total = 0;
   int bad = 0;

   rule110_host_ctrl #(
      .NUM_BLOCKS (16),
      .ADDR_BITS  (6),
      .CNT_W      (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy),
      .done      (done),
      .pin_data  (pin_data),
      .pin_ctrl  (pin_ctrl),
      .pin_q     (pin_q)
   );

   always #5 clk = ~clk;

   // Rule 110 with cell i+1 as left neighbour and zero outside the array.
   function automatic v_t rule_step(input v_t c);
      v_t n;
      logic l, r;
      n = '0;
      for (int i = 0; i < 128; i++) begin
         l = (i < 127) ? c[i+1] : 1'b0;
         r = (i > 0) ? c[i-1] : 1'b0;
         n[i] = RULE110[{l, c[i], r}];
      end
      return n;
   endfunction

   function automatic v_t gen_n(input v_t c, input int n);
      v_t s;
      s = c;
      for (int i = 0; i < n; i++) s = rule_step(s);
      return s;
   endfunction

   // Target model: stores cells, writes on we_n low, steps on halt_n high,
   // and shows the successor of the addressed block on pin_q.
   v_t cells = '0;
   v_t succ;
   int steps = 0;
   int wr_cnt = 0;
   int wide_pulses = 0;
   int halt_run = 0;
   int last_run = 0;
   logic prev_we_low = 1'b0;
   logic [5:0] wr_addr [256];

   always_comb begin
      succ = rule_step(cells);
      pin_q = (pin_ctrl[7:2] < 6'd16) ? succ[8*int'(pin_ctrl[7:2]) +: 8] : 8'h00;
   end

   always @(posedge clk) begin
      if (!pin_ctrl[0]) begin
         if (pin_ctrl[7:2] < 6'd16) cells[8*int'(pin_ctrl[7:2]) +: 8] <= pin_data;
         wr_addr[wr_cnt % 256] <= pin_ctrl[7:2];
         wr_cnt <= wr_cnt + 1;
         if (prev_we_low) wide_pulses <= wide_pulses + 1;
      end else if (pin_ctrl[1]) begin
         cells <= rule_step(cells);
         steps <= steps + 1;
      end
      prev_we_low <= !pin_ctrl[0];
      if (pin_ctrl[1]) halt_run <= halt_run + 1;
      else begin
         if (halt_run != 0) last_run <= halt_run;
         halt_run <= 0;
      end
   end

   task automatic check(input string tag, input v_t got, input v_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 100) begin @(posedge clk); #1; n++; end
      if (!done) check(tag, v_t'(done), v_t'(1));
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
      int n = 0;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!cmd_ready) check("cmd_ready_timeout", v_t'(cmd_ready), v_t'(1));
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 2'b11; cmd_arg = '0;
   endtask

   task automatic load(input v_t img, input bit gap);
      send_cmd(OP_LOAD, 16'd0);
      for (int b = 0; b < 16; b++) begin
         int n = 0;
         wr_valid = 1'b1; wr_data = img[8*b +: 8];
         while (!wr_ready && n < 20) begin @(posedge clk); #1; n++; end
         if (!wr_ready) check("wr_ready_timeout", v_t'(wr_ready), v_t'(1));
         @(posedge clk); #1;
         wr_valid = 1'b0;
         if (gap) begin @(posedge clk); #1; end
      end
      wait_done("load_done");
   endtask

   task automatic dump(input int hold_blk, output v_t img);
      logic [7:0] held;
      img = '0;
      send_cmd(OP_DUMP, 16'd0);
      for (int b = 0; b < 16; b++) begin
         int n = 0;
         while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
         if (!rd_valid) check("rd_valid_timeout", v_t'(rd_valid), v_t'(1));
         if (b == hold_blk) begin
            held = rd_data;
            for (int k = 0; k < 10; k++) begin
               @(posedge clk); #1;
               check("hold_valid", v_t'(rd_valid), v_t'(1));
               check("hold_data", v_t'(rd_data), v_t'(held));
               check("hold_addr", v_t'(pin_ctrl[7:2]), v_t'(b));
               check("hold_halt_n", v_t'(pin_ctrl[1]), v_t'(0));
            end
         end
         check("rd_last", v_t'(rd_last), v_t'(b == 15));
         img[8*b +: 8] = rd_data;
         rd_ready = 1'b1;
         @(posedge clk); #1;
         rd_ready = 1'b0;
      end
      wait_done("dump_done");
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      v_t got, pre, img4;
      int s0, w0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", v_t'(cmd_ready), v_t'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_pin_ctrl", v_t'(pin_ctrl), v_t'(8'h01));
      check("rst_pin_data", v_t'(pin_data), v_t'(0));
      check("rst_busy", v_t'(busy), v_t'(0));
      check("rst_done", v_t'(done), v_t'(0));
      check("rst_rd_valid", v_t'(rd_valid), v_t'(0));
      check("rst_wr_ready", v_t'(wr_ready), v_t'(0));
      check("idle_cmd_ready", v_t'(cmd_ready), v_t'(1));

      // Single seed: successor of cell 0 alone is cells 0 and 1
      load(v_t'(1), 1'b0);
      dump(-1, got);
      check("seed_dump", got, v_t'(128'h03));

      // RUN 0: no halt pulse, done right after accept, contents unchanged
      pre = got;
      s0 = steps;
      send_cmd(OP_RUN, 16'd0);
      check("run0_done", v_t'(done), v_t'(1));
      @(posedge clk); #1;
      check("run0_steps", v_t'(steps - s0), v_t'(0));
      dump(-1, got);
      check("run0_dump", got, pre);

      // RUN 5 from single seed: dump shows generation 6 = 1110011b
      load(v_t'(1), 1'b0);
      s0 = steps;
      send_cmd(OP_RUN, 16'd5);
      wait_done("run5_done");
      @(posedge clk); #1;
      check("run5_steps", v_t'(steps - s0), v_t'(5));
      check("run5_halt_width", v_t'(last_run), v_t'(5));
      dump(-1, got);
      check("run5_dump", got, v_t'(128'h73));

      // LOAD with wr_valid toggling, then DUMP stalled on block 3
      img4 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      w0 = wr_cnt;
      load(img4, 1'b1);
      @(posedge clk); #1;
      check("gap_we_pulses", v_t'(wr_cnt - w0), v_t'(16));
      check("gap_we_wide", v_t'(wide_pulses), v_t'(0));
      for (int i = 0; i < 16; i++)
         check("gap_we_addr", v_t'(wr_addr[(w0 + i) % 256]), v_t'(i));
      dump(3, got);
      check("stall_dump", got, rule_step(img4));

      // Reset after 500 of 1000 generations
      load(v_t'(1), 1'b0);
      s0 = steps;
      send_cmd(OP_RUN, 16'd1000);
      begin
         int n = 0;
         while (!pin_ctrl[1] && n < 20) begin @(posedge clk); #1; n++; end
         if (!pin_ctrl[1]) check("run1000_halt_timeout", v_t'(pin_ctrl[1]), v_t'(1));
      end
      repeat (499) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_pin_ctrl", v_t'(pin_ctrl), v_t'(8'h01));
      check("abort_busy", v_t'(busy), v_t'(0));
      check("abort_cmd_ready", v_t'(cmd_ready), v_t'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_steps", v_t'(steps - s0), v_t'(500));
      dump(-1, got);
      check("abort_dump", got, gen_n(v_t'(1), 501));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
